// File: rtl/ahb_bus_arbiter_if.sv
// Bundle of the per-master request/address/data vectors and the shared AHB-Lite bus
// that the arbiter drives. The master modport is the environment (bridges plus slave ready).
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    M_HBUSREQ;
    logic [32*NUM_MASTERS-1:0] M_HADDR;
    logic [2*NUM_MASTERS-1:0]  M_HTRANS;
    logic [3*NUM_MASTERS-1:0]  M_HSIZE;
    logic [3*NUM_MASTERS-1:0]  M_HBURST;
    logic [NUM_MASTERS-1:0]    M_HWRITE;
    logic [32*NUM_MASTERS-1:0] M_HWDATA;
    logic                      HREADY;

    logic [NUM_MASTERS-1:0]    M_HGRANT;
    logic [1:0]                HMASTER;
    logic                      bus_owned;
    logic [31:0]               HADDR;
    logic [1:0]                HTRANS;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic                      HWRITE;
    logic [31:0]               HWDATA;

    modport master (
        output M_HBUSREQ, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE, M_HWDATA, HREADY,
        input  M_HGRANT, HMASTER, bus_owned, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA
    );

    modport slave (
        input  M_HBUSREQ, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE, M_HWDATA, HREADY,
        output M_HGRANT, HMASTER, bus_owned, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter with a hold limit, plus the address-phase and
// data-phase multiplexers that put the owning master onto the shared bus.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic               clk,
    input  logic               rst,
    ahb_bus_arbiter_if.slave   bus
);
    localparam logic [1:0] LAST_IDX   = 2'(NUM_MASTERS - 1);
    localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD - 1);

    // Per-master slices padded to four entries so a 2-bit index never leaves the array.
    logic [31:0] addr_arr  [4];
    logic [1:0]  trans_arr [4];
    logic [2:0]  size_arr  [4];
    logic [2:0]  burst_arr [4];
    logic        write_arr [4];
    logic [31:0] wdata_arr [4];
    logic        req_arr   [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            if (gi < NUM_MASTERS) begin : g_used
                assign addr_arr[gi]  = bus.M_HADDR[32*gi +: 32];
                assign trans_arr[gi] = bus.M_HTRANS[2*gi +: 2];
                assign size_arr[gi]  = bus.M_HSIZE[3*gi +: 3];
                assign burst_arr[gi] = bus.M_HBURST[3*gi +: 3];
                assign write_arr[gi] = bus.M_HWRITE[gi];
                assign wdata_arr[gi] = bus.M_HWDATA[32*gi +: 32];
                assign req_arr[gi]   = bus.M_HBUSREQ[gi];
            end else begin : g_unused
                assign addr_arr[gi]  = '0;
                assign trans_arr[gi] = '0;
                assign size_arr[gi]  = '0;
                assign burst_arr[gi] = '0;
                assign write_arr[gi] = 1'b0;
                assign wdata_arr[gi] = '0;
                assign req_arr[gi]   = 1'b0;
            end
        end
    endgenerate

    logic [1:0]             owner_reg, owner_next;
    logic                   owner_valid_reg, owner_valid_next;
    logic [1:0]             last_owner_reg, last_owner_next;
    logic [4:0]             hold_cnt_reg, hold_cnt_next;
    logic [1:0]             data_owner_reg, data_owner_next;
    logic                   data_valid_reg, data_valid_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;

    logic       rr_found, oth_found;
    logic [1:0] rr_idx, oth_idx;
    logic [1:0] cand_idx;
    int         cand;

    // Round-robin search starting after last_owner; the "other" search skips the
    // current owner and is used when the hold limit forces a handover.
    always_comb begin
        rr_found  = 1'b0;
        rr_idx    = '0;
        oth_found = 1'b0;
        oth_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = int'(last_owner_reg) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = cand[1:0];
            if (!rr_found && req_arr[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
            if (!oth_found && req_arr[cand_idx] && (cand_idx != owner_reg)) begin
                oth_found = 1'b1;
                oth_idx   = cand_idx;
            end
        end
    end

    logic [1:0] htrans_mux;

    assign htrans_mux = owner_valid_reg ? trans_arr[owner_reg] : 2'b00;
    assign bus.HTRANS = htrans_mux;
    assign bus.HADDR  = owner_valid_reg ? addr_arr[owner_reg]  : '0;
    assign bus.HSIZE  = owner_valid_reg ? size_arr[owner_reg]  : '0;
    assign bus.HBURST = owner_valid_reg ? burst_arr[owner_reg] : '0;
    assign bus.HWRITE = owner_valid_reg ? write_arr[owner_reg] : 1'b0;
    assign bus.HWDATA = data_valid_reg  ? wdata_arr[data_owner_reg] : '0;

    assign bus.M_HGRANT  = grant_reg;
    assign bus.HMASTER   = owner_reg;
    assign bus.bus_owned = owner_valid_reg;

    logic       new_grant;
    logic [1:0] winner;

    always_comb begin
        owner_next       = owner_reg;
        owner_valid_next = owner_valid_reg;
        last_owner_next  = last_owner_reg;
        hold_cnt_next    = hold_cnt_reg;
        data_owner_next  = data_owner_reg;
        data_valid_next  = data_valid_reg;
        new_grant        = 1'b0;
        winner           = '0;

        if (bus.HREADY) begin
            data_owner_next = owner_reg;
            data_valid_next = owner_valid_reg & htrans_mux[1];

            if (!owner_valid_reg || !req_arr[owner_reg]) begin
                if (rr_found) begin
                    new_grant = 1'b1;
                    winner    = rr_idx;
                end else begin
                    owner_valid_next = 1'b0;
                end
            end else if ((hold_cnt_reg == HOLD_LIMIT) && oth_found) begin
                new_grant = 1'b1;
                winner    = oth_idx;
            end else if (hold_cnt_reg != 5'd31) begin
                hold_cnt_next = hold_cnt_reg + 5'd1;
            end

            if (new_grant) begin
                owner_next       = winner;
                owner_valid_next = 1'b1;
                last_owner_next  = winner;
                hold_cnt_next    = '0;
            end
        end

        grant_next = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_next[i] = owner_valid_next && (owner_next == 2'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg       <= '0;
            owner_valid_reg <= 1'b0;
            last_owner_reg  <= LAST_IDX;
            hold_cnt_reg    <= '0;
            data_owner_reg  <= '0;
            data_valid_reg  <= 1'b0;
            grant_reg       <= '0;
        end else begin
            owner_reg       <= owner_next;
            owner_valid_reg <= owner_valid_next;
            last_owner_reg  <= last_owner_next;
            hold_cnt_reg    <= hold_cnt_next;
            data_owner_reg  <= data_owner_next;
            data_valid_reg  <= data_valid_next;
            grant_reg       <= grant_next;
        end
    end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB-Lite arbiter and master-side multiplexer sharing the single system AHB bus between up to four CPU-side AHB masters (instruction-fetch and data-memory bridges, optionally debug/DMA). It samples each master's `M_HBUSREQ` and returns a registered one-hot `M_HGRANT`. It drives the shared address/control bus from the address-phase owner and `HWDATA` from the data-phase owner. It sits between the master bridges and the address decoder/slave mux.

## Interface
- `NUM_MASTERS`, 2: number of masters, 1..4; master 0 is index 0 of every packed vector.
- `MAX_HOLD`, 16: cycles an owner may keep the bus while another master requests, ≥1.

- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `M_HBUSREQ` in NUM_MASTERS: per-master bus request.
- `M_HADDR` in 32*NUM_MASTERS: master i at [32i+31:32i].
- `M_HTRANS` in 2*NUM_MASTERS: per-master transfer type.
- `M_HSIZE` in 3*NUM_MASTERS: per-master transfer size.
- `M_HBURST` in 3*NUM_MASTERS: per-master burst type.
- `M_HWRITE` in NUM_MASTERS: per-master write flag.
- `M_HWDATA` in 32*NUM_MASTERS: per-master write data.
- `HREADY` in 1: slave-side ready; 1 = current data phase completes this cycle.
- `M_HGRANT` out NUM_MASTERS: registered one-hot grant, all-zero when unowned.
- `HMASTER` out 2: index of the address-phase owner.
- `bus_owned` out 1: 1 when some master holds the grant.
- `HADDR` out 32, `HTRANS` out 2, `HSIZE` out 3, `HBURST` out 3, `HWRITE` out 1: shared bus, address phase.
- `HWDATA` out 32: shared bus, data phase.

## Operation
- **State registers:**
  - `owner` (2 b) with `owner_valid`.
  - `last_owner` (2 b), the round-robin pointer.
  - `hold_cnt` (5 b, saturating).
  - `data_owner` (2 b) with `data_valid`.
- **Arbitration** is evaluated only at a rising edge with `HREADY`=1. With `HREADY`=0 all state registers hold.
  - **Unowned:** grant the first requesting master searching `last_owner`+1, +2, … modulo NUM_MASTERS. If none, stay unowned.
  - **Owned, owner's `M_HBUSREQ`=0:** apply the same search. If no requester, go unowned.
  - **Owned, owner requesting, `hold_cnt`=MAX_HOLD-1, another master requesting:** grant the first other requester in round-robin order.
  - **Otherwise:** keep the owner and increment `hold_cnt` (saturates at 31).
- **On every new grant:**
  - `owner` = winner, `owner_valid`=1, `last_owner` = winner, `hold_cnt`=0.
  - A grant to the same index after a release counts as new.
- **Going unowned:** `owner_valid`=0. `last_owner` and `HMASTER` keep their previous value.
- **`M_HGRANT`** = one-hot of `owner` when `owner_valid`, else 0. `HMASTER` = `owner`. `bus_owned` = `owner_valid`.
- **Address mux:**
  - `owner_valid`=1: `HADDR`/`HTRANS`/`HSIZE`/`HBURST`/`HWRITE` are the owner's slices.
  - Unowned: `HTRANS`=2'b00 (IDLE) and all other address/control outputs are 0.
  - Non-granted masters never reach the bus, whatever they drive.
- **Data phase tracking** at each edge with `HREADY`=1:
  - `data_owner` ← `owner`.
  - `data_valid` ← `owner_valid` & `HTRANS`[1] (the muxed value).
- **`HWDATA`** = `M_HWDATA` slice of `data_owner` when `data_valid`, else 0.
- **Simultaneous requests** are resolved purely by round-robin order from `last_owner`+1, with no fixed priority.
- **Index range:** indices ≥ NUM_MASTERS are never granted. A single-master configuration (NUM_MASTERS=1) degenerates to grant-on-request.

## Timing
- **Reset values:**
  - `M_HGRANT`=0, `HMASTER`=0, `bus_owned`=0.
  - `HTRANS`=2'b00; `HADDR`, `HSIZE`, `HBURST`, `HWRITE`, `HWDATA` = 0.
  - `last_owner`=NUM_MASTERS-1, so master 0 wins the first tie.
  - `hold_cnt`=0, `data_valid`=0.
- **Reset mid-transfer:** outputs return to reset values immediately (asynchronous); no transfer completion is owed.
- **Grant latency:** `M_HBUSREQ` rising in cycle N with `HREADY`=1 gives `M_HGRANT` in cycle N+1, and the bus carries that master's address phase from cycle N+1.
- **Grant stall:** each `HREADY`=0 cycle delays a grant or handover by one cycle.
- **Handover:** when the owner drops `M_HBUSREQ` in cycle N (`HREADY`=1), the new owner's address appears in N+1. In N+1 `HWDATA` still comes from the old owner if its last transfer was NONSEQ/SEQ.
- **Data-phase offset:** `HWDATA` follows the address phase by exactly one `HREADY`-qualified cycle.
- **Combinational paths:** all outputs except `M_HGRANT`, `HMASTER` and `bus_owned` are combinational from registered state plus master inputs. No combinational path exists from `HREADY` to any output.

## Test plan
- **Reset, then idle:** `rst`=0 then 1 with no requests → `M_HGRANT`=0, `HTRANS`=00, `HADDR`=0 for 10 cycles.
- **Single master write:** master 1 requests, addr 0x2000_0010, NONSEQ, write, wdata 0xDEADBEEF, `HREADY`=1 → `M_HGRANT`=2'b10 next cycle; `HADDR`=0x2000_0010 that cycle; `HWDATA`=0xDEADBEEF the following cycle.
- **Simultaneous requests after reset:** masters 0 and 1 request together → master 0 granted first. It releases → master 1 granted the next cycle. Both request again → master 0 wins, since round-robin continues after `last_owner`=1.
- **Hold limit:** MAX_HOLD=4, master 0 holds the bus and master 1 requests continuously → handover to master 1 exactly 4 `HREADY` cycles after master 0's grant.
- **HREADY stall:** `HREADY`=0 for 3 cycles while master 0 releases and master 1 requests → grant, `HMASTER` and `HWDATA` source unchanged until the first `HREADY`=1 edge; master 1 is granted one cycle later.
- **Asynchronous reset mid-burst:** assert `rst` low between clock edges during a master 1 transfer → `M_HGRANT`=0 and `HTRANS`=00 without waiting for `clk`; after release, master 0 wins a tie.
